// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver feeding a FIFO with a registered read port; upstream byte source for the DMA.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose the parity_err pulse.
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int PTR_W        = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    input  logic             re,
    output logic [7:0]       data_out,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             frame_err,
    output logic             overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int                BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_sync_a;
    logic               r_rx_s;
    logic [BAUD_W-1:0]  r_baud;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [7:0]         r_data_out;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_half_tick;
    logic               w_bit_tick;
    logic               w_last_bit;
    logic               w_baud_clr;
    logic               w_bit_clr;
    logic               w_shift_en;
    logic               w_stop_done;
    logic               w_par_bad;
    logic               w_good;
    logic               w_pop;
    logic               w_push;
    logic               w_ovr;
    logic               w_ferr;

`ifdef UART_RX_PARITY_EN
    logic               r_par_bit;
    logic               r_parity_err;
    logic               w_par_en;
    logic               w_perr;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync_a <= 1'b1;
            r_rx_s   <= 1'b1;
        end else begin
            r_sync_a <= rx;
            r_rx_s   <= r_sync_a;
        end
    end

    assign w_half_tick = (r_baud == HALF_M1);
    assign w_bit_tick  = (r_baud == FULL_M1);
    assign w_last_bit  = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!r_rx_s) w_state_nxt = S_START;
            S_START:  if (w_half_tick) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (w_bit_tick && w_last_bit) w_state_nxt = S_PARITY;
            S_PARITY: if (w_bit_tick) w_state_nxt = S_STOP;
`else
            S_DATA:   if (w_bit_tick && w_last_bit) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_bit_tick) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_baud_clr  = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_stop_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_clr = 1'b1;
                w_bit_clr  = 1'b1;
            end
            S_START: begin
                w_bit_clr  = 1'b1;
                w_baud_clr = w_half_tick;
            end
            S_DATA: begin
                w_baud_clr = w_bit_tick;
                w_shift_en = w_bit_tick;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_baud_clr = w_bit_tick;
                w_par_en   = w_bit_tick;
            end
`endif
            S_STOP: begin
                w_baud_clr  = w_bit_tick;
                w_stop_done = w_bit_tick;
            end
            default: begin
                w_baud_clr = 1'b1;
                w_bit_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_baud <= w_baud_clr ? '0 : r_baud + BAUD_W'(1);
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // Data bits arrive LSB first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (w_shift_en) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
        end
`ifdef UART_RX_PARITY_EN
        if (w_par_en) begin
            r_par_bit <= r_rx_s;
        end
`endif
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = (r_par_bit != ^r_shift);
    assign w_perr    = w_stop_done && w_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    // A pop in the same cycle frees the head slot, so a full FIFO can still accept the byte.
    assign w_pop  = re && !empty;
    assign w_good = w_stop_done && !w_par_bad && r_rx_s;
    assign w_push = w_good && (!full || w_pop);
    assign w_ovr  = w_good && full && !w_pop;
    assign w_ferr = w_stop_done && !w_par_bad && !r_rx_s;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_data_out <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err  <= w_ferr;
            r_overrun    <= w_ovr;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_perr;
`endif
        end
    end

    assign data_out  = r_data_out;
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign full      = (r_count == DEPTH_C);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: directed and random frames checked against a queue-based byte model.
module tb_uart_rx_buffer;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rx = 1'b1;
    logic          re = 1'b0;
    logic [7:0]    data_out;
    logic          empty;
    logic          full;
    logic [PW:0]   count;
    logic          frame_err;
    logic          overrun;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    uart_rx_buffer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .PTR_W       (PW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .re        (re),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse counters: cycles on which each flag was high.
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    int exp_pe = 0;

    logic [7:0] q[$];
    logic [7:0] exp_dout = 8'h00;

    always @(posedge clk) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends one frame then applies the frame's outcome to the byte model.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int gap);
        bit pbad;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^b) ^ !par_ok);
        pbad = !par_ok;
`else
        pbad = 1'b0;
`endif
        bit_time(stop_ok);
        rx = 1'b1;
        tick(gap);
        if (pbad) exp_pe++;
        else if (!stop_ok) exp_fe++;
        else if (q.size() == DEPTH) exp_ov++;
        else q.push_back(b);
    endtask

    // Holds re high for n cycles and checks each popped byte.
    task automatic read_n(input int n, input string tag);
        re = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() > 0) exp_dout = q.pop_front();
            chk({tag, "_data"}, 32'(data_out), 32'(exp_dout));
        end
        re = 1'b0;
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, "_full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, "_ferr"},  32'(fe_cnt), 32'(exp_fe));
        chk({tag, "_ovr"},   32'(ov_cnt), 32'(exp_ov));
        chk({tag, "_perr"},  32'(pe_cnt), 32'(exp_pe));
    endtask

    initial begin
        logic [7:0] rb;
        bit         stop_ok;

        tick(3);
        chk("rst_dout",  32'(data_out), 32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_ovr",   32'(overrun), 32'h0);
        chk_status("rst");
        rstn = 1'b1;
        tick(4);

        // Single byte then a single read.
        chk("t1_pre_count", 32'(count), 32'h0);
        send_frame(8'hA1, 1'b1, 1'b1, 4);
        chk_status("t1_rx");
        read_n(1, "t1_rd");
        chk("t1_empty", 32'(empty), 32'h1);

        // Back-to-back frames, then four consecutive reads.
        send_frame(8'hA1, 1'b1, 1'b1, 0);
        send_frame(8'hB2, 1'b1, 1'b1, 0);
        send_frame(8'hC3, 1'b1, 1'b1, 0);
        send_frame(8'hD4, 1'b1, 1'b1, 4);
        chk_status("t2_rx");
        read_n(4, "t2_rd");
        chk("t2_empty", 32'(empty), 32'h1);

        // Fill past capacity: one overrun, then drain across the pointer wrap.
        for (int i = 0; i < DEPTH + 1; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1, 1'b1, 2);
        end
        chk_status("t3_full");
        read_n(DEPTH, "t3_rd");
        chk_status("t3_drained");

        // Bad stop bit, then a good frame; gap lets the line settle after the low stop bit.
        send_frame(8'h5C, 1'b0, 1'b1, 2 * CPB);
        chk_status("t4_ferr");
        send_frame(8'h6D, 1'b1, 1'b1, 4);
        chk_status("t4_good");
        read_n(1, "t4_rd");

        // Short glitch on rx must not start a frame; re on empty leaves data_out.
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(3 * CPB);
        chk_status("t5_glitch");
        read_n(2, "t5_rd_empty");

        // Reset in the middle of a data bit, then a clean frame.
        rx = 1'b0;
        tick(CPB);
        rb = 8'h7E;
        for (int i = 0; i < 3; i++) begin
            rx = rb[i];
            tick(CPB);
        end
        rstn = 1'b0;
        rx = 1'b1;
        tick(3);
        q.delete();
        exp_dout = 8'h00;
        chk("t6_rst_dout", 32'(data_out), 32'h0);
        chk_status("t6_rst");
        rstn = 1'b1;
        tick(4);
        send_frame(8'h8F, 1'b1, 1'b1, 4);
        chk_status("t6_rx");
        read_n(1, "t6_rd");
`ifdef UART_RX_PARITY_EN
        send_frame(8'h8F, 1'b1, 1'b0, 4);
        chk_status("t6_perr");
`endif

        // Random mix of frames (some with bad stop bits) and reads.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 9) < 6) begin
                rb      = 8'($urandom);
                stop_ok = ($urandom_range(0, 5) != 0);
                send_frame(rb, stop_ok, 1'b1, stop_ok ? 2 : 2 * CPB);
            end else begin
                read_n($urandom_range(1, 3), "rnd_rd");
            end
            chk_status("rnd");
        end
        read_n(q.size() + 1, "final_rd");
        chk_status("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
